// File: rtl/apb_modport_pkg.sv
// -----------------------------------------------------------------------------
// apb_modport_pkg
// Shared constants, the APB phase type and a one-hot helper for the
// apb_modport completer and its bus interface.
// -----------------------------------------------------------------------------
package apb_modport_pkg;

  localparam int NUM_SLV = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_e;

  // True when exactly one bit of the select vector is set.
  function automatic logic is_one_hot(input logic [NUM_SLV-1:0] v);
    return (v != '0) && ((v & (v - NUM_SLV'(1))) == '0);
  endfunction

endpackage

// File: rtl/apb_modport_if.sv
// -----------------------------------------------------------------------------
// apb_modport_if
// APB bus bundle between the bridge (master) and the 4-way completer (slave).
//   pselx   : one-hot slave select, bit n selects bank n
//   penable : access-phase qualifier
//   pwrite  : 1 = write, 0 = read
//   paddr   : byte address
//   pwdata  : write data
//   prdata  : registered read data from the completer
// -----------------------------------------------------------------------------
interface apb_modport_if;
  import apb_modport_pkg::*;

  logic [NUM_SLV-1:0] pselx;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata
  );

endinterface

// File: rtl/apb_modport_bank.sv
// -----------------------------------------------------------------------------
// apb_modport_bank
// One DEPTH x DATA_W register bank with asynchronous clear.
//   clk   : clock, writes on posedge
//   rst   : asynchronous active-high clear of every word
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : combinational read data
// -----------------------------------------------------------------------------
module apb_modport_bank
  import apb_modport_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // DEPTH is a power of two, so every index is in range.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_modport.sv
// -----------------------------------------------------------------------------
// apb_modport
// APB completer behind a 4-way pselx decode: four independent word-addressed
// register banks, one per select line, no wait states.
//   clk : clock, all state changes on posedge
//   rst : asynchronous active-high reset (clears banks and prdata)
//   bus : apb_modport_if.slave (pselx, penable, pwrite, paddr, pwdata, prdata)
// Reads load prdata on the posedge ending the setup cycle, so data is stable
// for the whole access cycle; writes commit on the posedge ending access.
// Optional macro APB_MODPORT_ADDR_CHK_EN: nonzero paddr bits above the word
// index make writes ignored and reads return 0. Without it, addresses alias
// modulo DEPTH words.
// -----------------------------------------------------------------------------
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  apb_modport_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_SLV);

  apb_phase_e         phase;
  logic               one_hot;
  logic               addr_ok;
  logic               unused_paddr;
  logic [SEL_W-1:0]   sel_idx;
  logic [AW-1:0]      word_idx;
  logic [NUM_SLV-1:0] bank_we;
  logic [DATA_W-1:0]  bank_rdata [NUM_SLV];
  logic [DATA_W-1:0]  prdata_d;
  logic [DATA_W-1:0]  prdata_q;

  assign word_idx = bus.paddr[AW+1:2];
  assign one_hot  = is_one_hot(bus.pselx);

  // Phase is classified from the current bus signals alone; an access cycle
  // without a preceding setup is still treated as an access.
  always_comb begin
    phase = IDLE;
    if (bus.pselx != '0) begin
      phase = bus.penable ? ACCESS : SETUP;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int n = 0; n < NUM_SLV; n++) begin
      if (bus.pselx[n]) begin
        sel_idx = SEL_W'(n);
      end
    end
  end

`ifdef APB_MODPORT_ADDR_CHK_EN
  assign addr_ok      = (bus.paddr[ADDR_W-1:AW+2] == '0);
  assign unused_paddr = ^bus.paddr[1:0];
`else
  assign addr_ok      = 1'b1;
  assign unused_paddr = ^{bus.paddr[ADDR_W-1:AW+2], bus.paddr[1:0]};
`endif

  for (genvar n = 0; n < NUM_SLV; n++) begin : g_bank
    // Multi-hot selects never write; one_hot guards against that.
    assign bank_we[n] = (phase == ACCESS) && bus.pwrite && bus.pselx[n]
                        && one_hot && addr_ok;

    apb_modport_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[n]),
      .waddr (word_idx),
      .wdata (bus.pwdata),
      .raddr (word_idx),
      .rdata (bank_rdata[n])
    );
  end

  // prdata reloads only on a read setup and otherwise holds.
  always_comb begin
    prdata_d = prdata_q;
    if (phase == SETUP && !bus.pwrite) begin
      prdata_d = (one_hot && addr_ok) ? bank_rdata[sel_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata_q <= '0;
    end else begin
      prdata_q <= prdata_d;
    end
  end

  assign bus.prdata = prdata_q;

endmodule

// File: tb/tb_apb_modport.sv
// -----------------------------------------------------------------------------
// tb_apb_modport
// Directed bench for apb_modport (DEPTH = 16). Inputs change on the negedge,
// prdata is sampled on the negedge inside the read's access cycle.
// -----------------------------------------------------------------------------
module tb_apb_modport;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [31:0] rd;

  apb_modport_if bus ();

  apb_modport #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running, expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.pselx   = '0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] data);
    @(negedge clk);
    bus.pselx = sel; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = addr; bus.pwdata = data;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic do_read(input logic [3:0] sel, input logic [31:0] addr,
                         output logic [31:0] data);
    @(negedge clk);
    bus.pselx = sel; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = addr;
    @(negedge clk);
    bus.penable = 1'b1;
    data = bus.prdata;
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    bus_idle();

    // Reset
    #2 rst = 1'b1;
    #2 check("reset_prdata", bus.prdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: fresh bank reads zero
    do_read(4'b0100, 32'h14, rd);
    check("rd_b2_i5_after_reset", rd, 32'h0);

    // 2: write then read bank 0, plus ignored byte offset
    do_write(4'b0001, 32'h0C, 32'hA5A5_1234);
    do_read(4'b0001, 32'h0C, rd);
    check("rd_b0_0c", rd, 32'hA5A5_1234);
    @(negedge clk);
    check("prdata_hold_idle", bus.prdata, 32'hA5A5_1234);
    do_read(4'b0001, 32'h0F, rd);
    check("rd_b0_0f_byte_ignored", rd, 32'hA5A5_1234);

    // 3: banks independent
    do_write(4'b0001, 32'h10, 32'h1111_1111);
    do_write(4'b1000, 32'h10, 32'h2222_2222);
    do_read(4'b0001, 32'h10, rd);
    check("rd_b0_10", rd, 32'h1111_1111);
    do_read(4'b1000, 32'h10, rd);
    check("rd_b3_10", rd, 32'h2222_2222);

    // 4: multi-hot write ignored, multi-hot read returns 0
    do_write(4'b0110, 32'h0, 32'hFFFF_FFFF);
    do_read(4'b0010, 32'h0, rd);
    check("rd_b1_0_after_multihot", rd, 32'h0);
    do_read(4'b0001, 32'h0C, rd);
    do_read(4'b0100, 32'h0, rd);
    check("rd_b2_0_after_multihot", rd, 32'h0);
    do_read(4'b0001, 32'h0C, rd);
    check("rd_b0_0c_again", rd, 32'hA5A5_1234);
    do_read(4'b0110, 32'h0C, rd);
    check("rd_multihot_zero", rd, 32'h0);

    // pselx = 0 read setup leaves prdata alone
    do_read(4'b0001, 32'h0C, rd);
    @(negedge clk);
    bus.pselx = 4'b0000; bus.pwrite = 1'b0; bus.paddr = 32'h10;
    @(negedge clk);
    check("prdata_hold_psel0", bus.prdata, 32'hA5A5_1234);
    bus_idle();

    // 5: upper address bits
    do_write(4'b0010, 32'h40, 32'hDEAD_BEEF);
`ifdef APB_MODPORT_ADDR_CHK_EN
    do_read(4'b0001, 32'h0C, rd);
    do_read(4'b0010, 32'h40, rd);
    check("rd_b1_40_chk", rd, 32'h0);
    do_read(4'b0010, 32'h00, rd);
    check("rd_b1_00_chk", rd, 32'h0);
`else
    do_read(4'b0010, 32'h00, rd);
    check("rd_b1_00_alias", rd, 32'hDEAD_BEEF);
    do_read(4'b0010, 32'h40, rd);
    check("rd_b1_40_alias", rd, 32'hDEAD_BEEF);
`endif

    // Back-to-back write then read of the same address
    @(negedge clk);
    bus.pselx = 4'b0001; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h20; bus.pwdata = 32'h7777_0001;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.penable = 1'b0; bus.pwrite = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    check("b2b_write_read", bus.prdata, 32'h7777_0001);
    @(negedge clk);
    bus_idle();

    // Access without setup: write performed, read does not reload
    @(negedge clk);
    bus.pselx = 4'b0100; bus.penable = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = 32'h08; bus.pwdata = 32'h3C3C_3C3C;
    @(negedge clk);
    bus_idle();
    do_read(4'b0100, 32'h08, rd);
    check("access_only_write", rd, 32'h3C3C_3C3C);
    @(negedge clk);
    bus.pselx = 4'b0100; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = 32'h00;
    @(negedge clk);
    check("access_only_read_hold", bus.prdata, 32'h3C3C_3C3C);
    bus_idle();

    // 6: reset during a write access
    do_read(4'b1000, 32'h10, rd);
    check("rd_b3_10_pre_reset", rd, 32'h2222_2222);
    @(negedge clk);
    bus.pselx = 4'b1000; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h14; bus.pwdata = 32'h5555_5555;
    @(negedge clk);
    bus.penable = 1'b1;
    #2 rst = 1'b1;
    #1 check("prdata_async_clear", bus.prdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_idle();
    do_read(4'b1000, 32'h14, rd);
    check("rd_b3_14_dropped", rd, 32'h0);
    do_read(4'b0001, 32'h0C, rd);
    check("rd_b0_0c_cleared", rd, 32'h0);
    do_write(4'b1000, 32'h14, 32'h0000_0006);
    do_read(4'b1000, 32'h14, rd);
    check("rd_b3_14_post_reset", rd, 32'h0000_0006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_modport.md
# apb_modport

APB completer model that sits on the bridge side of the AHB-to-APB path, behind the 4-way `pselx` decode. It holds four independent word-addressed register banks, one per select line. Writes are accepted in the APB access phase. Read data is presented on `prdata` from the access phase onward, so that a posedge-driven responder and a negedge-sampling monitor both see stable data.

## Interface

Parameters:
- `DEPTH`, default 16: words per bank; must be a power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: word-index width; derived, not overridden.

Ports:
- `clk`, input, 1: the block's one clock; all state changes on the posedge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `pselx`, input, 4: one-hot slave select; bit n selects bank n.
- `penable`, input, 1: APB access-phase qualifier.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, 32: byte address.
- `pwdata`, input, 32: write data.
- `prdata`, output, 32: read data, registered.

## Operation

Phases:
- Setup: `pselx` one-hot and `penable=0`.
- Access: `pselx` one-hot and `penable=1`.
- No wait states: every access completes in one cycle, and there is no `pready`.

Addressing:
- Word index is `paddr[AW+1:2]`.
- `paddr[1:0]` is ignored.
- Bank is the index of the set `pselx` bit.

Write:
- Occurs on the posedge ending an access cycle with `pwrite=1`.
- Stores `pwdata` into bank[sel][index].

Read:
- On the posedge ending a setup cycle with `pwrite=0`, `prdata` loads bank[sel][index].
- It then holds through the access phase and afterwards, until the next read setup.

Select errors:
- `pselx` = 0: no effect; `prdata` holds.
- `pselx` multi-hot: no write; a read setup loads `prdata` = 0.

Access phase without a preceding setup:
- A write is still performed.
- A read does not reload `prdata`.

Reset:
- `rst` asynchronously clears every word of every bank to 0.
- `rst` asynchronously clears `prdata` to 0.

## Timing

- Read latency: `prdata` is valid one posedge after setup, i.e. for the whole access cycle. It is therefore stable at the following negedge.
- Write latency: the stored value is visible to a read whose setup cycle starts on the posedge that ends the write's access cycle. Back-to-back write then read to the same address returns the new data.
- Reset mid-transfer:
  - A pending write is dropped.
  - `prdata` goes to 0 immediately.
  - The first setup after `rst` deasserts is handled normally.

## Configuration

Macro: `APB_MODPORT_ADDR_CHK_EN`.
- Defined: if `paddr[31:AW+2]` is nonzero, a write is ignored and a read loads `prdata` = 0.
- Undefined: upper address bits are ignored, so addresses alias modulo DEPTH words.

## Structure

- Package `apb_modport_pkg` holds:
  - `NUM_SLV` = 4;
  - `DATA_W` = 32;
  - `ADDR_W` = 32;
  - the `apb_phase_e` enum (IDLE, SETUP, ACCESS).
- One sub-module, `apb_modport_bank`:
  - single DEPTH×32 register array with async clear;
  - one write port and one combinational read port;
  - instantiated `NUM_SLV` times.
- Top level: select decode, one-hot check, address check, and the `prdata` register.

## Test plan

1. Reset, then read bank 2 index 5 -> `prdata` = 0.
2. Write 0xA5A5_1234 at `pselx`=4'b0001, `paddr`=0x0C, then read the same address -> `prdata` = 0xA5A5_1234 in the read's access cycle.
3. Write 0x1111_1111 to bank 0 and 0x2222_2222 to bank 3 at `paddr`=0x10, then read both -> 0x1111_1111 and 0x2222_2222 (banks independent).
4. `pselx`=4'b0110 write of 0xFFFF_FFFF to 0x0, then a proper read of bank 1 and bank 2 at 0x0 -> both 0. The multi-hot read itself returns 0.
5. With the macro defined, write 0xDEAD_BEEF to `paddr`=0x40 (DEPTH=16) -> read of 0x40 = 0, read of 0x00 = 0. Without the macro, read of 0x00 = 0xDEAD_BEEF.
6. Assert `rst` during the access phase of a write of 0x5555_5555 -> `prdata` = 0 at once, and a later read of that address = 0.
